// File: rtl/vigenere_key_seq_if.sv
// Stream bundle between the key sequencer, its byte source and the cipher stage.
// The slave view is the sequencer itself: it takes bytes in on the s_* side
// and presents them with a shift and direction on the m_* side.
// The master view is whatever drives the byte stream and consumes the result.
interface vigenere_key_seq_if #(
    parameter int N = 8
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic [1:0]   mode;
    logic         m_en;
    logic         m_ready;
    logic [N-1:0] m_din;
    logic [4:0]   m_shift_num;
    logic [1:0]   m_direction;

    modport slave (
        input  s_valid, s_data, mode, m_ready,
        output s_ready, m_en, m_din, m_shift_num, m_direction
    );

    modport master (
        output s_valid, s_data, mode, m_ready,
        input  s_ready, m_en, m_din, m_shift_num, m_direction
    );
endinterface

// File: rtl/vigenere_key_seq.sv
// Vigenere key sequencer: stores an alphabetic key, then tags every streamed
// byte with the next key letter as its shift amount for the cipher stage.
// Optional build macro KEY_SKIP_NONALPHA_EN: when defined, non-letter bytes
// pass with shift 0 and do not consume a key letter.
module vigenere_key_seq #(
    parameter int N         = 8,
    parameter int KEY_DEPTH = 16,
    parameter int KEY_AW    = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              key_clr,
    input  logic              key_wr,
    input  logic [7:0]        key_char,
    input  logic              key_lock,
    output logic [KEY_AW:0]   key_len,
    output logic              key_err,
    output logic              busy,
    vigenere_key_seq_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [KEY_AW:0]   DEPTH_L = (KEY_AW + 1)'(KEY_DEPTH);
    localparam logic [KEY_AW:0]   LEN_ONE = (KEY_AW + 1)'(1);
    localparam logic [KEY_AW-1:0] IDX_ONE = KEY_AW'(1);

    state_t            state;
    state_t            state_next;
    logic [4:0]        key_mem [KEY_DEPTH];
    logic [KEY_AW-1:0] idx;
    logic              store;
    logic              accept;
    logic              consume;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [4:0] letter_code(input logic [7:0] c);
        if (c >= 8'h61) begin
            return 5'(c - 8'h61);
        end
        return 5'(c - 8'h41);
    endfunction

    // A key write only lands while the key is still open, the character is a
    // letter and there is room left; clear always wins over a write.
    assign store = key_wr && !key_clr && (state != RUN) &&
                   is_letter(key_char) && (key_len < DEPTH_L);

    // One-entry output register: take a new byte whenever the slot is empty
    // or being drained this cycle.
    assign bus.s_ready = (state == RUN) && (!bus.m_en || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready && !key_clr;
    assign busy        = (state == RUN);

`ifdef KEY_SKIP_NONALPHA_EN
    assign consume = is_letter(8'(bus.s_data));
`else
    assign consume = 1'b1;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: first letter opens the key, lock freezes it (a letter
    // written in the same cycle is included), clear always returns to EMPTY.
    always_comb begin
        state_next = state;
        if (key_clr) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (store) state_next = key_lock ? RUN : LOAD;
                LOAD:    if (key_lock) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Key letter storage; contents need no reset because key_len gates use.
    always_ff @(posedge clock) begin
        if (!rst && store) begin
            key_mem[key_len[KEY_AW-1:0]] <= letter_code(key_char);
        end
    end

    // Key length and the sticky error flag for rejected writes or empty locks.
    always_ff @(posedge clock) begin
        if (rst || key_clr) begin
            key_len <= '0;
            key_err <= 1'b0;
        end else begin
            if (store) begin
                key_len <= key_len + LEN_ONE;
            end
            if (key_wr && !store) begin
                key_err <= 1'b1;
            end
            if (key_lock && (state == EMPTY) && !store) begin
                key_err <= 1'b1;
            end
        end
    end

    // Output register and key index: capture on accept, hold under
    // backpressure, and let the slot empty when the cipher stage takes it.
    always_ff @(posedge clock) begin
        if (rst) begin
            bus.m_en          <= 1'b0;
            bus.m_din         <= '0;
            bus.m_shift_num   <= '0;
            bus.m_direction   <= '0;
            idx               <= '0;
        end else if (key_clr) begin
            bus.m_en <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            bus.m_en        <= 1'b1;
            bus.m_din       <= bus.s_data;
            bus.m_direction <= bus.mode;
            bus.m_shift_num <= consume ? key_mem[idx] : 5'd0;
            if (consume) begin
                if ({1'b0, idx} == (key_len - LEN_ONE)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_ONE;
                end
            end
        end else if (bus.m_ready) begin
            bus.m_en <= 1'b0;
        end
    end

endmodule
